// File: rtl/sqrt_pkg.sv
// Shared types and elaboration helpers for the iterative square-root engine.
package sqrt_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_e;

   function automatic bit check_even(input int unsigned w);
      return (w >= 2) && ((w % 2) == 0);
   endfunction

   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      while ((64'd1 << r) < 64'(v)) r++;
      return r;
   endfunction

endpackage

// File: rtl/sqrt_step.sv
// One digit-by-digit square-root iteration: brings in the next operand bit
// pair, tries {root,01} against the remainder and emits the next root bit.
module sqrt_step #(
   parameter int unsigned RW = 4
) (
   input  logic [RW+1:0] rem_i,
   input  logic [RW-1:0] root_i,
   input  logic [1:0]    pair_i,
   output logic [RW+1:0] rem_o,
   output logic [RW-1:0] root_o
);

   logic [RW+1:0] shifted;
   logic [RW+1:0] trial;
   logic          ge;

   always_comb begin
      shifted = (rem_i << 2) | {{RW{1'b0}}, pair_i};
      trial   = {root_i, 2'b01};
      ge      = (shifted >= trial);
      rem_o   = ge ? (shifted - trial) : shifted;
      root_o  = (root_i << 1) | RW'(ge);
   end

endmodule

// File: rtl/sqrt_finder_iter.sv
// Iterative integer square root, one root bit per clock, with optional
// round-to-nearest and a saturation flag; start/busy/done handshake.
module sqrt_finder_iter
   import sqrt_pkg::*;
#(
   parameter int unsigned DATA_W = 8
) (
   input  logic                clk,
   input  logic                clr_n,
   input  logic                start,
   input  logic [DATA_W-1:0]   data,
   input  logic                round_en,
   output logic                busy,
   output logic                done,
   output logic [DATA_W/2-1:0] root_out,
   output logic [DATA_W/2:0]   rem_out,
   output logic                sat
);

   localparam int unsigned   RW   = DATA_W / 2;
   localparam int unsigned   CW   = clog2(RW) + 1;
   localparam logic [CW-1:0] LAST = CW'(RW - 1);

   if (!check_even(DATA_W)) begin : g_bad_width
      $error("sqrt_finder_iter: DATA_W must be even and >= 2");
   end

   state_e            state_q, state_d;
   logic [DATA_W-1:0] op_q, op_d;
   logic              rnd_q, rnd_d;
   logic [RW+1:0]     rem_q, rem_d;
   logic [RW-1:0]     root_q, root_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [RW-1:0]     root_out_q, root_out_d;
   logic [RW:0]       rem_out_q, rem_out_d;
   logic              sat_q, sat_d;

   logic [RW+1:0]     step_rem;
   logic [RW-1:0]     step_root;
   logic              round_up;
   logic              root_max;

   // Operand is consumed MSB pair first by shifting it left each iteration.
   sqrt_step #(.RW(RW)) u_step (
      .rem_i  (rem_q),
      .root_i (root_q),
      .pair_i (op_q[DATA_W-1 -: 2]),
      .rem_o  (step_rem),
      .root_o (step_root)
   );

   assign round_up = rnd_q && (step_rem > {2'b00, step_root});
   assign root_max = &step_root;

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state_q    <= IDLE;
         op_q       <= '0;
         rnd_q      <= 1'b0;
         rem_q      <= '0;
         root_q     <= '0;
         cnt_q      <= '0;
         root_out_q <= '0;
         rem_out_q  <= '0;
         sat_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         rnd_q      <= rnd_d;
         rem_q      <= rem_d;
         root_q     <= root_d;
         cnt_q      <= cnt_d;
         root_out_q <= root_out_d;
         rem_out_q  <= rem_out_d;
         sat_q      <= sat_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      rnd_d      = rnd_q;
      rem_d      = rem_q;
      root_d     = root_q;
      cnt_d      = cnt_q;
      root_out_d = root_out_q;
      rem_out_d  = rem_out_q;
      sat_d      = sat_q;
      unique case (state_q)
         IDLE, DONE: begin
            if (start) begin
               op_d    = data;
               rnd_d   = round_en;
               rem_d   = '0;
               root_d  = '0;
               cnt_d   = '0;
               state_d = CALC;
            end
         end
         CALC: begin
            op_d   = op_q << 2;
            rem_d  = step_rem;
            root_d = step_root;
            cnt_d  = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
               state_d    = DONE;
               rem_out_d  = step_rem[RW:0];
               root_out_d = (round_up && !root_max) ? step_root + RW'(1) : step_root;
               sat_d      = round_up && root_max;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy     = (state_q == CALC);
   assign done     = (state_q == DONE);
   assign root_out = root_out_q;
   assign rem_out  = rem_out_q;
   assign sat      = sat_q;

endmodule

// File: tb/tb_sqrt_finder_iter.sv
// Self-checking bench: 8-bit and 16-bit engines against an arithmetic sqrt model.
module tb_sqrt_finder_iter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       clr_n;
   logic       start8, rnd8, busy8, done8, sat8;
   logic [7:0] data8;
   logic [3:0] root8;
   logic [4:0] rem8;

   logic        start16, rnd16, busy16, done16, sat16;
   logic [15:0] data16;
   logic [7:0]  root16;
   logic [8:0]  rem16;

   sqrt_finder_iter #(.DATA_W(8)) u_dut8 (
      .clk(clk), .clr_n(clr_n), .start(start8), .data(data8), .round_en(rnd8),
      .busy(busy8), .done(done8), .root_out(root8), .rem_out(rem8), .sat(sat8)
   );

   sqrt_finder_iter #(.DATA_W(16)) u_dut16 (
      .clk(clk), .clr_n(clr_n), .start(start16), .data(data16), .round_en(rnd16),
      .busy(busy16), .done(done16), .root_out(root16), .rem_out(rem16), .sat(sat16)
   );

   int n_checks = 0;
   int n_fail   = 0;

   int unsigned prev_root [2];
   int unsigned prev_rem  [2];
   bit          prev_sat  [2];

   task automatic check_eq(input string tag, input longint unsigned got, input longint unsigned exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   function automatic void ref_sqrt(input int unsigned x, input int unsigned rw, input bit rnd,
                                    output int unsigned r, output int unsigned m, output bit s);
      r = 0;
      while ((r + 1) * (r + 1) <= x) r++;
      m = x - r * r;
      s = 1'b0;
      if (rnd && (m > r)) begin
         if (r == (32'd1 << rw) - 1) s = 1'b1;
         else                        r = r + 1;
      end
   endfunction

   task automatic drive(input bit w16, input bit st, input int unsigned d, input bit rnd);
      if (w16) begin
         start16 = st; data16 = d[15:0]; rnd16 = rnd;
      end else begin
         start8 = st;  data8 = d[7:0];   rnd8 = rnd;
      end
   endtask

   task automatic check_outs(input bit w16, input string tag, input bit eb, input bit ed,
                             input int unsigned er, input int unsigned em, input bit es);
      if (w16) begin
         check_eq({tag, ".busy16"}, busy16, eb);
         check_eq({tag, ".done16"}, done16, ed);
         check_eq({tag, ".root16"}, root16, er);
         check_eq({tag, ".rem16"},  rem16,  em);
         check_eq({tag, ".sat16"},  sat16,  es);
      end else begin
         check_eq({tag, ".busy8"}, busy8, eb);
         check_eq({tag, ".done8"}, done8, ed);
         check_eq({tag, ".root8"}, root8, er);
         check_eq({tag, ".rem8"},  rem8,  em);
         check_eq({tag, ".sat8"},  sat8,  es);
      end
   endtask

   // One transaction; 'mid' injects a start with all-ones data during CALC.
   task automatic run(input bit w16, input int unsigned d, input bit rnd, input bit mid);
      int unsigned rw, er, em;
      bit          es;
      int          idx;
      rw  = w16 ? 8 : 4;
      idx = w16 ? 1 : 0;
      ref_sqrt(d, rw, rnd, er, em, es);
      @(negedge clk);
      drive(w16, 1'b1, d, rnd);
      @(posedge clk); #1;
      check_outs(w16, "accept", 1'b1, 1'b0, prev_root[idx], prev_rem[idx], prev_sat[idx]);
      for (int unsigned i = 1; i <= rw; i++) begin
         @(negedge clk);
         if (mid && i == 2) drive(w16, 1'b1, 32'hFFFF_FFFF, 1'b1);
         else               drive(w16, 1'b0, $urandom, 1'($urandom));
         @(posedge clk); #1;
         if (i < rw) check_outs(w16, "calc",   1'b1, 1'b0, prev_root[idx], prev_rem[idx], prev_sat[idx]);
         else        check_outs(w16, "result", 1'b0, 1'b1, er, em, es);
      end
      prev_root[idx] = er;
      prev_rem[idx]  = em;
      prev_sat[idx]  = es;
   endtask

   initial begin
      int unsigned er, em;
      bit          es;
      for (int k = 0; k < 2; k++) begin
         prev_root[k] = 0; prev_rem[k] = 0; prev_sat[k] = 1'b0;
      end
      clr_n = 1'b0;
      drive(1'b0, 1'b0, 0, 1'b0);
      drive(1'b1, 1'b0, 0, 1'b0);
      #12;
      check_outs(1'b0, "reset", 1'b0, 1'b0, 0, 0, 1'b0);
      check_outs(1'b1, "reset", 1'b0, 1'b0, 0, 0, 1'b0);
      @(negedge clk);
      clr_n = 1'b1;

      run(1'b0, 0,   1'b0, 1'b0);
      run(1'b0, 36,  1'b0, 1'b0);
      run(1'b0, 150, 1'b0, 1'b0);
      run(1'b0, 157, 1'b1, 1'b0);
      run(1'b0, 156, 1'b1, 1'b0);
      run(1'b0, 255, 1'b1, 1'b0);
      run(1'b0, 255, 1'b0, 1'b0);
      run(1'b0, 36,  1'b0, 1'b1);
      run(1'b0, 255, 1'b1, 1'b0);

      // start held high across the DONE edge: done lasts one cycle, then recompute
      ref_sqrt(200, 4, 1'b0, er, em, es);
      @(negedge clk);
      drive(1'b0, 1'b1, 200, 1'b0);
      @(posedge clk);
      repeat (3) @(posedge clk);
      @(posedge clk); #1;
      check_outs(1'b0, "hold.done", 1'b0, 1'b1, er, em, es);
      @(posedge clk); #1;
      check_outs(1'b0, "hold.recalc", 1'b1, 1'b0, er, em, es);
      @(negedge clk);
      drive(1'b0, 1'b0, 200, 1'b0);
      repeat (3) @(posedge clk);
      @(posedge clk); #1;
      check_outs(1'b0, "hold.result", 1'b0, 1'b1, er, em, es);
      prev_root[0] = er; prev_rem[0] = em; prev_sat[0] = es;

      // asynchronous reset in the middle of CALC
      @(negedge clk);
      drive(1'b0, 1'b1, 150, 1'b0);
      @(posedge clk);
      @(negedge clk);
      drive(1'b0, 1'b0, 150, 1'b0);
      @(posedge clk);
      @(negedge clk);
      clr_n = 1'b0;
      #1;
      check_outs(1'b0, "midrst", 1'b0, 1'b0, 0, 0, 1'b0);
      for (int k = 0; k < 2; k++) begin
         prev_root[k] = 0; prev_rem[k] = 0; prev_sat[k] = 1'b0;
      end
      @(negedge clk);
      clr_n = 1'b1;
      repeat (2) @(posedge clk); #1;
      check_outs(1'b0, "postrst", 1'b0, 1'b0, 0, 0, 1'b0);
      run(1'b0, 36, 1'b0, 1'b0);

      repeat (24) run(1'b0, $urandom_range(0, 255), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

      run(1'b1, 65535, 1'b0, 1'b0);
      run(1'b1, 40000, 1'b1, 1'b0);
      run(1'b1, 65535, 1'b1, 1'b0);
      repeat (10) run(1'b1, $urandom_range(0, 65535), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
